// File: rtl/kfmmc_block_buffer.sv
// Host-side 512-byte sector buffer and command sequencer for the KFMMC drive strobe interface.
// Issues address/command strobes after a host start, then moves bytes on drive byte interrupts.
module kfmmc_block_buffer #(
    parameter logic [7:0] read_command      = 8'h80,
    parameter logic [7:0] write_command     = 8'h81,
    parameter int         buffer_depth_log2 = 9
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                host_block_address,
    input  logic [24:0]                host_block_address_extension,
    input  logic                       host_start_read,
    input  logic                       host_start_write,
    input  logic                       host_write_strobe,
    input  logic [7:0]                 host_write_byte,
    input  logic                       host_read_strobe,
    output logic [7:0]                 host_read_byte,
    input  logic                       host_clear_pointer,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [buffer_depth_log2:0] transfer_count,
    output logic [7:0]                 data_bus,
    output logic [24:0]                data_bus_extension,
    output logic                       write_block_address_1,
    output logic                       write_block_address_2,
    output logic                       write_block_address_3,
    output logic                       write_block_address_4,
    output logic                       write_block_address_extension,
    output logic                       write_access_command,
    output logic                       write_data,
    output logic                       read_data,
    input  logic [7:0]                 read_data_byte,
    input  logic                       drive_busy,
    input  logic                       read_interface_error,
    input  logic                       read_crc_error,
    input  logic                       write_interface_error,
    input  logic                       read_byte_interrupt,
    input  logic                       read_completion_interrupt,
    input  logic                       request_write_data_interrupt,
    input  logic                       write_completion_interrupt
);
    localparam int depth = 2 ** buffer_depth_log2;
    localparam logic [buffer_depth_log2:0] full_count = {1'b1, {buffer_depth_log2{1'b0}}};

    typedef enum logic [3:0] {
        IDLE, EXT, ADDR1, ADDR2, ADDR3, ADDR4, CMD, XFER_READ, XFER_WRITE, FEED, DONE
    } state_t;

    state_t                         state;
    logic [7:0]                     buffer [depth];
    logic [buffer_depth_log2-1:0]   host_ptr;
    logic [buffer_depth_log2-1:0]   drive_ptr;
    logic [31:0]                    addr_q;
    logic                           dir_write;
    logic                           cmpl_pend;
    logic                           count_full;

    logic                           host_we;
    logic                           drive_we;
    logic                           ram_we;
    logic [buffer_depth_log2-1:0]   ram_waddr;
    logic [7:0]                     ram_wdata;

    // Single RAM write port shared by host fill (IDLE only) and drive read data (XFER_READ only).
    always_comb begin
        count_full = (transfer_count == full_count);
        host_we    = (state == IDLE) && host_write_strobe && !host_clear_pointer;
        drive_we   = (state == XFER_READ) && read_byte_interrupt && !count_full;
        ram_we     = host_we || drive_we;
        ram_waddr  = drive_we ? drive_ptr : host_ptr;
        ram_wdata  = drive_we ? read_data_byte : host_write_byte;
    end

    always_ff @(posedge clock) begin
        if (ram_we)
            buffer[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                         <= IDLE;
            busy                          <= 1'b0;
            done                          <= 1'b0;
            error                         <= 1'b0;
            transfer_count                <= '0;
            data_bus                      <= '0;
            data_bus_extension            <= '0;
            host_read_byte                <= '0;
            host_ptr                      <= '0;
            drive_ptr                     <= '0;
            addr_q                        <= '0;
            dir_write                     <= 1'b0;
            cmpl_pend                     <= 1'b0;
            write_block_address_1         <= 1'b0;
            write_block_address_2         <= 1'b0;
            write_block_address_3         <= 1'b0;
            write_block_address_4         <= 1'b0;
            write_block_address_extension <= 1'b0;
            write_access_command          <= 1'b0;
            write_data                    <= 1'b0;
            read_data                     <= 1'b0;
        end else begin
            // Strobes are registered on the transition into the state that owns them.
            write_block_address_1         <= 1'b0;
            write_block_address_2         <= 1'b0;
            write_block_address_3         <= 1'b0;
            write_block_address_4         <= 1'b0;
            write_block_address_extension <= 1'b0;
            write_access_command          <= 1'b0;
            write_data                    <= 1'b0;
            read_data                     <= 1'b0;
            done                          <= 1'b0;

            case (state)
                IDLE: begin
                    if (host_clear_pointer) begin
                        host_ptr <= '0;
                    end else if (host_write_strobe) begin
                        host_ptr <= host_ptr + 1'b1;
                    end else if (host_read_strobe) begin
                        host_read_byte <= buffer[host_ptr];
                        host_ptr       <= host_ptr + 1'b1;
                    end
                    if (!drive_busy && (host_start_read || host_start_write)) begin
                        addr_q                        <= host_block_address;
                        data_bus_extension            <= host_block_address_extension;
                        dir_write                     <= !host_start_read;
                        drive_ptr                     <= '0;
                        transfer_count                <= '0;
                        error                         <= 1'b0;
                        cmpl_pend                     <= 1'b0;
                        busy                          <= 1'b1;
                        write_block_address_extension <= 1'b1;
                        state                         <= EXT;
                    end
                end
                EXT: begin
                    data_bus              <= addr_q[7:0];
                    write_block_address_1 <= 1'b1;
                    state                 <= ADDR1;
                end
                ADDR1: begin
                    data_bus              <= addr_q[15:8];
                    write_block_address_2 <= 1'b1;
                    state                 <= ADDR2;
                end
                ADDR2: begin
                    data_bus              <= addr_q[23:16];
                    write_block_address_3 <= 1'b1;
                    state                 <= ADDR3;
                end
                ADDR3: begin
                    data_bus              <= addr_q[31:24];
                    write_block_address_4 <= 1'b1;
                    state                 <= ADDR4;
                end
                ADDR4: begin
                    data_bus             <= dir_write ? write_command : read_command;
                    write_access_command <= 1'b1;
                    state                <= CMD;
                end
                CMD: begin
                    state <= dir_write ? XFER_WRITE : XFER_READ;
                end
                XFER_READ: begin
                    error <= error | (read_byte_interrupt && count_full)
                                   | (read_completion_interrupt
                                      && (read_interface_error || read_crc_error));
                    // A byte event wins; a coincident completion is kept and honoured next cycle.
                    if (read_byte_interrupt) begin
                        read_data <= 1'b1;
                        drive_ptr <= drive_ptr + 1'b1;
                        if (!count_full)
                            transfer_count <= transfer_count + 1'b1;
                        if (read_completion_interrupt)
                            cmpl_pend <= 1'b1;
                    end else if (read_completion_interrupt || cmpl_pend) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                XFER_WRITE: begin
                    error <= error | (write_completion_interrupt && write_interface_error);
                    if (request_write_data_interrupt) begin
                        data_bus   <= buffer[drive_ptr];
                        write_data <= 1'b1;
                        state      <= FEED;
                        if (write_completion_interrupt)
                            cmpl_pend <= 1'b1;
                    end else if (write_completion_interrupt || cmpl_pend) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                FEED: begin
                    error     <= error | (write_completion_interrupt && write_interface_error);
                    drive_ptr <= drive_ptr + 1'b1;
                    if (!count_full)
                        transfer_count <= transfer_count + 1'b1;
                    if (write_completion_interrupt)
                        cmpl_pend <= 1'b1;
                    state <= XFER_WRITE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kfmmc_block_buffer.sv
// Scoreboard bench for kfmmc_block_buffer: stimulus pushes expected drive/host responses,
// a negedge monitor pops and compares them whenever the DUT asserts an output.
module tb_kfmmc_block_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] host_block_address = '0;
    logic [24:0] host_block_address_extension = '0;
    logic        host_start_read = 1'b0, host_start_write = 1'b0;
    logic        host_write_strobe = 1'b0, host_read_strobe = 1'b0, host_clear_pointer = 1'b0;
    logic [7:0]  host_write_byte = '0, host_read_byte;
    logic        busy, done, error;
    logic [9:0]  transfer_count;
    logic [7:0]  data_bus;
    logic [24:0] data_bus_extension;
    logic        write_block_address_1, write_block_address_2, write_block_address_3;
    logic        write_block_address_4, write_block_address_extension, write_access_command;
    logic        write_data, read_data;
    logic [7:0]  read_data_byte = '0;
    logic        drive_busy = 1'b0, read_interface_error = 1'b0, read_crc_error = 1'b0;
    logic        write_interface_error = 1'b0, read_byte_interrupt = 1'b0;
    logic        read_completion_interrupt = 1'b0, request_write_data_interrupt = 1'b0;
    logic        write_completion_interrupt = 1'b0;

    kfmmc_block_buffer dut (
        .clock(clock), .reset(reset),
        .host_block_address(host_block_address),
        .host_block_address_extension(host_block_address_extension),
        .host_start_read(host_start_read), .host_start_write(host_start_write),
        .host_write_strobe(host_write_strobe), .host_write_byte(host_write_byte),
        .host_read_strobe(host_read_strobe), .host_read_byte(host_read_byte),
        .host_clear_pointer(host_clear_pointer),
        .busy(busy), .done(done), .error(error), .transfer_count(transfer_count),
        .data_bus(data_bus), .data_bus_extension(data_bus_extension),
        .write_block_address_1(write_block_address_1), .write_block_address_2(write_block_address_2),
        .write_block_address_3(write_block_address_3), .write_block_address_4(write_block_address_4),
        .write_block_address_extension(write_block_address_extension),
        .write_access_command(write_access_command),
        .write_data(write_data), .read_data(read_data), .read_data_byte(read_data_byte),
        .drive_busy(drive_busy), .read_interface_error(read_interface_error),
        .read_crc_error(read_crc_error), .write_interface_error(write_interface_error),
        .read_byte_interrupt(read_byte_interrupt),
        .read_completion_interrupt(read_completion_interrupt),
        .request_write_data_interrupt(request_write_data_interrupt),
        .write_completion_interrupt(write_completion_interrupt)
    );

    always #5 clock = ~clock;

    localparam int K_EXT = 0, K_A1 = 1, K_A2 = 2, K_A3 = 3, K_A4 = 4, K_CMD = 5;
    localparam int K_WD = 6, K_RD = 7, K_DONE = 8, K_HRD = 9;

    typedef struct {
        int          kind;
        logic [31:0] data;
        longint      cyc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  model [512];
    int          hp = 0;
    int          nchk = 0, nerr = 0;
    longint      cyc = 0;
    logic        hrd_v = 1'b0;
    logic [61:0] out_vec;

    assign out_vec = {busy, done, error, transfer_count, data_bus, data_bus_extension, host_read_byte,
                      write_block_address_1, write_block_address_2, write_block_address_3,
                      write_block_address_4, write_block_address_extension, write_access_command,
                      write_data, read_data};

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        hrd_v <= host_read_strobe && !reset;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(int k, logic [31:0] d, longint c);
        exp_t e;
        e.kind = k; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic mon(logic s, int k, logic [31:0] d, string nm);
        exp_t e;
        if (!s) return;
        nchk++;
        if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected %s: got data %h, expected no output", nm, d);
            return;
        end
        e = q.pop_front();
        if (e.kind != k || e.data !== d) begin
            nerr++;
            $display("FAIL %s: got kind %0d data %h, expected kind %0d data %h", nm, k, d, e.kind, e.data);
        end
        if (e.cyc >= 0) begin
            nchk++;
            if (e.cyc != cyc) begin
                nerr++;
                $display("FAIL %s timing: got cycle %0d expected %0d", nm, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            mon(write_block_address_extension, K_EXT, 32'(data_bus_extension), "ext");
            mon(write_block_address_1, K_A1, 32'(data_bus), "addr1");
            mon(write_block_address_2, K_A2, 32'(data_bus), "addr2");
            mon(write_block_address_3, K_A3, 32'(data_bus), "addr3");
            mon(write_block_address_4, K_A4, 32'(data_bus), "addr4");
            mon(write_access_command, K_CMD, 32'(data_bus), "cmd");
            mon(write_data, K_WD, 32'(data_bus), "write_data");
            mon(read_data, K_RD, 32'h0, "read_data");
            mon(done, K_DONE, {21'h0, error, transfer_count}, "done");
            mon(hrd_v, K_HRD, 32'(host_read_byte), "host_read_byte");
        end
    end

    function automatic logic [31:0] exp_done(logic e, int n);
        int c;
        c = (n > 512) ? 512 : n;
        return {21'h0, e, 10'(c)};
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clock);
            k++;
        end
        nchk++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL wait_idle: got %0d outstanding responses expected 0", q.size());
            q.delete();
        end
        @(negedge clock);
        chk("busy_after_done", 64'(busy), 64'h0);
    endtask

    task automatic host_write(logic [7:0] b);
        host_write_byte = b; host_write_strobe = 1'b1;
        model[hp] = b; hp = (hp + 1) % 512;
        @(negedge clock);
        host_write_strobe = 1'b0;
    endtask

    task automatic host_read();
        push(K_HRD, 32'(model[hp]), cyc + 1);
        host_read_strobe = 1'b1; hp = (hp + 1) % 512;
        @(negedge clock);
        host_read_strobe = 1'b0;
    endtask

    task automatic host_clear();
        host_clear_pointer = 1'b1; hp = 0;
        @(negedge clock);
        host_clear_pointer = 1'b0;
    endtask

    task automatic start_seq(logic rd, logic wr, logic [31:0] a, logic [24:0] x);
        logic [7:0] cmd;
        cmd = rd ? 8'h80 : 8'h81;
        push(K_EXT, 32'(x), cyc + 1);
        push(K_A1, 32'(a[7:0]), cyc + 2);
        push(K_A2, 32'(a[15:8]), cyc + 3);
        push(K_A3, 32'(a[23:16]), cyc + 4);
        push(K_A4, 32'(a[31:24]), cyc + 5);
        push(K_CMD, 32'(cmd), cyc + 6);
        host_block_address = a; host_block_address_extension = x;
        host_start_read = rd; host_start_write = wr;
        @(negedge clock);
        host_start_read = 1'b0; host_start_write = 1'b0;
        host_block_address = $urandom; host_block_address_extension = 25'($urandom);
        repeat (6) @(negedge clock);
    endtask

    task automatic drive_read(int n, logic crc, logic ife, logic with_last, logic pattern);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = pattern ? 8'(i) : 8'($urandom);
            if (i < 512) model[i] = b;
            push(K_RD, 32'h0, cyc + 1);
            read_data_byte = b; read_byte_interrupt = 1'b1;
            if (with_last && i == n - 1) begin
                push(K_DONE, exp_done(crc | ife | (n > 512), n), -1);
                read_completion_interrupt = 1'b1; read_crc_error = crc; read_interface_error = ife;
            end
            @(negedge clock);
            read_byte_interrupt = 1'b0; read_completion_interrupt = 1'b0;
            read_data_byte = $urandom;
            repeat ($urandom_range(1, 2)) @(negedge clock);
        end
        if (!with_last) begin
            push(K_DONE, exp_done(crc | ife | (n > 512), n), -1);
            read_completion_interrupt = 1'b1; read_crc_error = crc; read_interface_error = ife;
            @(negedge clock);
            read_completion_interrupt = 1'b0;
        end
        read_crc_error = 1'b0; read_interface_error = 1'b0;
        wait_idle();
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        chk("outputs_after_mid_reset", 64'(out_vec), 64'h0);
        reset = 1'b0; hp = 0;
        @(negedge clock);
    endtask

    task automatic drive_write(int n, logic ife, logic with_last, int reset_at);
        for (int i = 0; i < n; i++) begin
            if (i == reset_at) begin
                mid_reset();
                return;
            end
            push(K_WD, 32'(model[i % 512]), cyc + 1);
            request_write_data_interrupt = 1'b1;
            if (with_last && i == n - 1) begin
                push(K_DONE, exp_done(ife, n), -1);
                write_completion_interrupt = 1'b1; write_interface_error = ife;
            end
            @(negedge clock);
            request_write_data_interrupt = 1'b0; write_completion_interrupt = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clock);
        end
        if (!with_last) begin
            push(K_DONE, exp_done(ife, n), -1);
            write_completion_interrupt = 1'b1; write_interface_error = ife;
            @(negedge clock);
            write_completion_interrupt = 1'b0;
        end
        write_interface_error = 1'b0;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clock);
        chk("reset_state", 64'(out_vec), 64'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_after_reset", 64'(out_vec), 64'h0);

        // Address sequencing plus a full sector read with an i[7:0] byte pattern.
        start_seq(1'b1, 1'b0, 32'h12345678, 25'h1);
        drive_read(512, 1'b0, 1'b0, 1'b0, 1'b1);
        host_clear();
        for (int i = 0; i < 512; i++) host_read();
        wait_idle();

        // Full sector write of FF-i, with an ignored host strobe while busy.
        host_clear();
        for (int i = 0; i < 512; i++) host_write(8'hFF - 8'(i));
        start_seq(1'b0, 1'b1, $urandom, 25'($urandom));
        host_write_byte = 8'h5A; host_write_strobe = 1'b1;
        @(negedge clock);
        host_write_strobe = 1'b0;
        drive_write(512, 1'b0, 1'b1, -1);

        // CRC error reported, then cleared by a clean read; a start while busy is ignored.
        start_seq(1'b1, 1'b0, $urandom, 25'($urandom));
        host_start_read = 1'b1;
        @(negedge clock);
        host_start_read = 1'b0;
        drive_read(16, 1'b1, 1'b0, 1'b0, 1'b0);
        start_seq(1'b1, 1'b0, $urandom, 25'($urandom));
        drive_read(8, 1'b0, 1'b0, 1'b1, 1'b0);

        // Start while the drive is busy must be dropped.
        drive_busy = 1'b1; host_start_write = 1'b1;
        @(negedge clock);
        host_start_write = 1'b0;
        repeat (10) @(negedge clock);
        chk("no_start_while_drive_busy", 64'(busy), 64'h0);
        drive_busy = 1'b0;

        // Simultaneous starts: read wins.
        start_seq(1'b1, 1'b1, $urandom, 25'($urandom));
        drive_read(4, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overflow: bytes past 512 acknowledged, not stored, flagged.
        start_seq(1'b1, 1'b0, $urandom, 25'($urandom));
        drive_read(514, 1'b0, 1'b0, 1'b0, 1'b0);
        host_clear();
        for (int i = 0; i < 8; i++) host_read();
        wait_idle();

        // Write with interface error.
        start_seq(1'b0, 1'b1, $urandom, 25'($urandom));
        drive_write(10, 1'b1, 1'b0, -1);

        // Reset in the middle of a write, then a clean read.
        start_seq(1'b0, 1'b1, $urandom, 25'($urandom));
        drive_write(200, 1'b0, 1'b0, 100);
        start_seq(1'b1, 1'b0, $urandom, 25'($urandom));
        drive_read(3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized short transfers.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 0) begin
                start_seq(1'b1, 1'b0, $urandom, 25'($urandom));
                drive_read(n, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 1) == 1, 1'b0);
                host_clear();
                for (int i = 0; i < n; i++) host_read();
                wait_idle();
            end else begin
                host_clear();
                for (int i = 0; i < n; i++) host_write(8'($urandom));
                start_seq(1'b0, 1'b1, $urandom, 25'($urandom));
                drive_write(n, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, -1);
            end
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 64'(q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
